mips_multicycle_control: RTL and testbench



---
 rtl/mips_multicycle_control.sv | 182 ++++++++++++++++++
 tb/tb_mips_multicycle_control.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute and drives datapath controls.
// Optional macro MIPS_CTRL_ADDI_EN adds decode of addi (opcode 001000) via ADDI_EX/ADDI_WB.
//
// state   | meaning
// --------+---------------------------------------------------------------
// FETCH   | read instruction at PC, PC += 4, load IR when memory is ready
// DECODE  | read registers, precompute branch target, dispatch on opcode
// MEMADR  | compute lw/sw effective address
// MEMRD   | data memory read, wait for mem_ready
// MEMWB   | write loaded word to rt
// MEMWR   | data memory write, wait for mem_ready
// EXEC    | R-type ALU operation
// RWB     | write R-type result to rd
// BRANCH  | beq compare, conditional PC load
// JUMP    | unconditional PC load with jump target
// ADDI_EX | addi: A + sign-extended immediate
// ADDI_WB | addi: write result to rt

module mips_multicycle_control #(
    parameter bit MEM_WAIT_EN_DEFAULT = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic [1:0] PCSource,
    output logic [1:0] ALUOp,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXEC    = 4'd6,
        RWB     = 4'd7,
        BRANCH  = 4'd8,
        JUMP    = 4'd9,
        ADDI_EX = 4'd10,
        ADDI_WB = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MIPS_CTRL_ADDI_EN
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

    state_t state_q;
    state_t state_d;
    logic   rdy;

    // With waiting disabled every memory access completes in one cycle.
    assign rdy   = MEM_WAIT_EN_DEFAULT ? mem_ready : 1'b1;
    assign state = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = FETCH;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        PCSource    = 2'b00;
        ALUOp       = 2'b00;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        illegal_op  = 1'b0;

        case (state_q)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = rdy;
                PCWrite = rdy;
                state_d = rdy ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXEC;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
`ifdef MIPS_CTRL_ADDI_EN
                    OP_ADDI:      state_d = ADDI_EX;
`endif
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (opcode == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                state_d = rdy ? MEMWB : MEMRD;
            end
            MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                state_d  = FETCH;
            end
            MEMWR: begin
                // Write request is held for the whole wait, not gated by rdy.
                MemWrite = 1'b1;
                IorD     = 1'b1;
                state_d  = rdy ? FETCH : MEMWR;
            end
            EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                state_d = RWB;
            end
            RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                state_d  = FETCH;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                state_d     = FETCH;
            end
            JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                state_d  = FETCH;
            end
`ifdef MIPS_CTRL_ADDI_EN
            ADDI_EX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = ADDI_WB;
            end
            ADDI_WB: begin
                RegWrite = 1'b1;
                state_d  = FETCH;
            end
`endif
            default: state_d = FETCH;
        endcase
    end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: reset, vector table, hand sequences, random vs phase-list model.
// Honours MIPS_CTRL_ADDI_EN the same way as the design.

module tb_mips_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
    logic [1:0] PCSource, ALUOp, ALUSrcB;
    logic       ALUSrcA, RegWrite, RegDst, illegal_op;
    logic [3:0] state;
    logic [16:0] dut_outs;

    int checks = 0;
    int errors = 0;

    mips_multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .IRWrite(IRWrite), .PCSource(PCSource), .ALUOp(ALUOp),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
        .RegDst(RegDst), .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    assign dut_outs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                       PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst, illegal_op};

`ifdef MIPS_CTRL_ADDI_EN
    localparam bit ADDI_ON = 1'b1;
`else
    localparam bit ADDI_ON = 1'b0;
`endif

    // Output table straight from the per-state control listing.
    function automatic logic [16:0] spec_outs(input int st, input logic rdy, input logic ill);
        logic pcw, pcwc, iord, mr, mw, m2r, irw, asa, rw, rd, il;
        logic [1:0] pcs, aop, asb;
        {pcw, pcwc, iord, mr, mw, m2r, irw, asa, rw, rd, il} = '0;
        pcs = 2'b00; aop = 2'b00; asb = 2'b00;
        case (st)
            0:  begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
            1:  begin asb = 2'b11; il = ill; end
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin mr = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mw = 1; iord = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rw = 1; rd = 1; end
            8:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
            9:  begin pcw = 1; pcs = 2'b10; end
            10: if (ADDI_ON) begin asa = 1; asb = 2'b10; end
            11: if (ADDI_ON) rw = 1;
            default: ;
        endcase
        return {pcw, pcwc, iord, mr, mw, m2r, irw, pcs, aop, asa, asb, rw, rd, il};
    endfunction

    // Phases an instruction walks through, independent of how the FSM encodes them.
    function automatic void phases(input logic [5:0] op, output int q[$]);
        case (op)
            6'b100011: q = '{0, 1, 2, 3, 4};
            6'b101011: q = '{0, 1, 2, 5};
            6'b000000: q = '{0, 1, 6, 7};
            6'b000100: q = '{0, 1, 8};
            6'b000010: q = '{0, 1, 9};
            6'b001000: if (ADDI_ON) q = '{0, 1, 10, 11}; else q = '{0, 1};
            default:   q = '{0, 1};
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [5:0]  op;
        int          waits;
        int          len;
        logic [63:0] seq;
    } vec_t;

    vec_t tbl[10];

    // Runs one instruction starting in FETCH; mem_ready is low for `waits` cycles from cycle 3.
    task automatic run_vec(input vec_t v, input int idx);
        logic [63:0] seq;
        int len;
        logic [3:0] exps;
        seq = '0;
        len = 20;
        for (int c = 0; c < 20; c++) begin
            mem_ready = !(c >= 3 && c < 3 + v.waits);
            opcode    = v.op;
            #1;
            if (c > 0 && state == 4'd0) begin
                len = c;
                break;
            end
            if (c < 16) seq[4*c +: 4] = state;
            if (c < v.len && c < 16) begin
                exps = v.seq[4*c +: 4];
                check($sformatf("vec%0d outs c%0d", idx, c), 64'(dut_outs),
                      64'(spec_outs(int'(exps), mem_ready, exps == 4'd1 && v.len == 2)));
            end
            @(posedge clk); #1;
        end
        check($sformatf("vec%0d len", idx), 64'(len), 64'(v.len));
        check($sformatf("vec%0d seq", idx), seq, v.seq);
    endtask

    initial begin
        int q[$];
        int idx;
        int exp_st;
        logic rdy;
        logic [5:0] op;

        tbl[0] = '{6'b100011, 0, 5, 64'h43210};
        tbl[1] = '{6'b101011, 3, 7, 64'h5555210};
        tbl[2] = '{6'b000000, 0, 4, 64'h7610};
        tbl[3] = '{6'b000100, 0, 3, 64'h810};
        tbl[4] = '{6'b000010, 0, 3, 64'h910};
        tbl[5] = '{6'b111111, 0, 2, 64'h10};
        tbl[6] = '{6'b100011, 2, 7, 64'h4333210};
        tbl[7] = '{6'b101011, 0, 4, 64'h5210};
        if (ADDI_ON) tbl[8] = '{6'b001000, 0, 4, 64'hBA10};
        else         tbl[8] = '{6'b001000, 0, 2, 64'h10};
        tbl[9] = '{6'b010101, 0, 2, 64'h10};

        // Reset behaviour
        rst_n = 1'b0; mem_ready = 1'b0; opcode = 6'b000000;
        @(posedge clk); #1;
        check("rst state", 64'(state), 64'd0);
        check("rst MemRead", 64'(MemRead), 64'd1);
        check("rst ALUSrcB", 64'(ALUSrcB), 64'd1);
        check("rst PCWrite", 64'(PCWrite), 64'd0);
        check("rst IRWrite", 64'(IRWrite), 64'd0);
        check("rst outs", 64'(dut_outs), 64'(spec_outs(0, 1'b0, 1'b0)));
        mem_ready = 1'b1;
        #1;
        check("fetch IRWrite rdy", 64'(IRWrite), 64'd1);
        check("fetch PCWrite rdy", 64'(PCWrite), 64'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("first decode", 64'(state), 64'd1);
        rst_n = 1'b0; #1; rst_n = 1'b1; #1;
        check("re-reset", 64'(state), 64'd0);

        for (int i = 0; i < 10; i++) run_vec(tbl[i], i);

        // Asynchronous reset in the middle of a stalled MEMRD
        opcode = 6'b100011; mem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        check("memrd stall", 64'(state), 64'd3);
        check("memrd RegWrite", 64'(RegWrite), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        check("async rst state", 64'(state), 64'd0);
        check("async rst MemRead", 64'(MemRead), 64'd1);
        check("async rst RegWrite", 64'(RegWrite), 64'd0);
        mem_ready = 1'b1;
        @(posedge clk); #1;
        check("rst held state", 64'(state), 64'd0);
        check("rst held RegWrite", 64'(RegWrite), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("resume decode", 64'(state), 64'd1);
        opcode = 6'b111111;
        #1;
        check("resume illegal", 64'(illegal_op), 64'd1);
        @(posedge clk); #1;
        check("back to fetch", 64'(state), 64'd0);
        check("illegal one cycle", 64'(illegal_op), 64'd0);

        // Random instruction stream against the phase-list model
        idx = 0;
        q.delete();
        op = 6'b000000;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (idx == 0) begin
                case ($urandom_range(0, 7))
                    0: op = 6'b100011;
                    1: op = 6'b101011;
                    2: op = 6'b000000;
                    3: op = 6'b000100;
                    4: op = 6'b000010;
                    5: op = 6'b001000;
                    default: op = 6'($urandom);
                endcase
                phases(op, q);
            end
            rdy = ($urandom_range(0, 3) != 0);
            mem_ready = rdy;
            opcode = op;
            #1;
            exp_st = q[idx];
            check("rand state+outs", {43'd0, state, dut_outs},
                  {43'd0, 4'(exp_st), spec_outs(exp_st, rdy, exp_st == 1 && q.size() == 2)});
            @(posedge clk); #1;
            if (!((exp_st == 0 || exp_st == 3 || exp_st == 5) && !rdy)) idx++;
            if (idx == q.size()) idx = 0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
